// File: rtl/lif_neuron_core_if.sv
// Bundles the per-neuron time-step strobe, synaptic inputs, configuration and observed state.
// The master side is the array controller or bench, and the slave side is the neuron core.
interface lif_neuron_core_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_IN     = 4,
  parameter int unsigned W_WIDTH  = 4,
  parameter int unsigned REFRAC_W = 4
);
  logic                      en;
  logic [N_IN-1:0]           spike_in;
  logic [N_IN*W_WIDTH-1:0]   weights;
  logic [WIDTH-1:0]          threshold;
  logic [WIDTH-1:0]          leak_amt;
  logic [REFRAC_W-1:0]       refrac_len;
  logic                      spike_out;
  logic [WIDTH-1:0]          membrane;
  logic                      refractory;

  modport master (
    output en, spike_in, weights, threshold, leak_amt, refrac_len,
    input  spike_out, membrane, refractory
  );

  modport slave (
    input  en, spike_in, weights, threshold, leak_amt, refrac_len,
    output spike_out, membrane, refractory
  );
endinterface

// File: rtl/lif_neuron_core.sv
// Multi-input leaky integrate-and-fire neuron with a saturating membrane and a refractory hold-off.
// Define LIF_ADAPTIVE_THRESH_EN to add a spike-driven adaptive threshold offset.
module lif_neuron_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_IN      = 4,
  parameter int unsigned W_WIDTH   = 4,
  parameter int unsigned REFRAC_W  = 4
`ifdef LIF_ADAPTIVE_THRESH_EN
  , parameter int unsigned ADAPT_INC = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  lif_neuron_core_if.slave  bus
);

  localparam int unsigned SUM_W = W_WIDTH + $clog2(N_IN + 1);
  localparam int unsigned ACC_W = ((WIDTH > SUM_W) ? WIDTH : SUM_W) + 1;
  localparam logic [WIDTH-1:0] V_MAX = '1;

  typedef enum logic [1:0] {
    REST      = 2'd0,
    INTEGRATE = 2'd1,
    FIRE      = 2'd2,
    REFRACT   = 2'd3
  } state_e;

  state_e               state_q, state_n;
  logic [WIDTH-1:0]     membrane_q, membrane_n;
  logic                 spike_q, spike_n;
  logic                 refr_q, refr_n;
  logic [REFRAC_W-1:0]  cnt_q, cnt_n;

  logic [SUM_W-1:0]     sum_c;
  logic [ACC_W-1:0]     acc_c;
  logic [ACC_W-1:0]     leak_ext_c;
  logic [ACC_W-1:0]     diff_c;
  logic [WIDTH-1:0]     v_tmp_c;
  logic [WIDTH-1:0]     eff_thresh_c;
  logic                 fire_c;

  // Weighted sum of the active synapses, wide enough to never overflow
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (bus.spike_in[i]) begin
        sum_c = sum_c + SUM_W'(bus.weights[i*W_WIDTH +: W_WIDTH]);
      end
    end
  end

  // Add before subtracting the leak, then floor at 0 and saturate to the membrane width
  always_comb begin
    acc_c      = ACC_W'(membrane_q) + ACC_W'(sum_c);
    leak_ext_c = ACC_W'(bus.leak_amt);
    diff_c     = '0;
    v_tmp_c    = '0;
    if (acc_c > leak_ext_c) begin
      diff_c = acc_c - leak_ext_c;
      if (diff_c > ACC_W'(V_MAX)) begin
        v_tmp_c = V_MAX;
      end else begin
        v_tmp_c = WIDTH'(diff_c);
      end
    end
  end

`ifdef LIF_ADAPTIVE_THRESH_EN
  logic [WIDTH-1:0] offset_q, offset_n;
  logic [WIDTH:0]   thr_sum_c;
  logic [WIDTH:0]   inc_sum_c;

  always_comb begin
    thr_sum_c    = (WIDTH+1)'(bus.threshold) + (WIDTH+1)'(offset_q);
    eff_thresh_c = thr_sum_c[WIDTH] ? V_MAX : thr_sum_c[WIDTH-1:0];
  end

  // Offset grows on every spike and relaxes by one per time step spent in REST
  always_comb begin
    offset_n  = offset_q;
    inc_sum_c = (WIDTH+1)'(offset_q) + (WIDTH+1)'(ADAPT_INC);
    if (state_n == FIRE && state_q != FIRE) begin
      offset_n = inc_sum_c[WIDTH] ? V_MAX : inc_sum_c[WIDTH-1:0];
    end else if (state_q == REST && bus.en && offset_q != '0) begin
      offset_n = offset_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_n;
    end
  end
`else
  always_comb begin
    eff_thresh_c = bus.threshold;
  end
`endif

  assign fire_c = (bus.threshold != '0) && (v_tmp_c >= eff_thresh_c);

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    membrane_n = membrane_q;
    spike_n    = 1'b0;
    refr_n     = refr_q;
    cnt_n      = cnt_q;
    case (state_q)
      REST, INTEGRATE: begin
        if (bus.en) begin
          if (fire_c) begin
            state_n    = FIRE;
            membrane_n = '0;
            spike_n    = 1'b1;
          end else begin
            membrane_n = v_tmp_c;
            state_n    = (v_tmp_c == '0) ? REST : INTEGRATE;
          end
        end
      end
      FIRE: begin
        membrane_n = '0;
        if (bus.refrac_len == '0) begin
          state_n = REST;
        end else begin
          state_n = REFRACT;
          cnt_n   = bus.refrac_len;
          refr_n  = 1'b1;
        end
      end
      REFRACT: begin
        membrane_n = '0;
        if (bus.en) begin
          if (cnt_q <= REFRAC_W'(1)) begin
            state_n = REST;
            cnt_n   = '0;
            refr_n  = 1'b0;
          end else begin
            cnt_n = cnt_q - REFRAC_W'(1);
          end
        end
      end
      default: begin
        state_n    = REST;
        membrane_n = '0;
        refr_n     = 1'b0;
        cnt_n      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REST;
      membrane_q <= '0;
      spike_q    <= 1'b0;
      refr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_n;
      membrane_q <= membrane_n;
      spike_q    <= spike_n;
      refr_q     <= refr_n;
      cnt_q      <= cnt_n;
    end
  end

  assign bus.spike_out  = spike_q;
  assign bus.membrane   = membrane_q;
  assign bus.refractory = refr_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core: expected outputs are queued per step and checked after the edge.
module tb_lif_neuron_core;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned N_IN     = 4;
  localparam int unsigned W_WIDTH  = 4;
  localparam int unsigned REFRAC_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] mem;
    logic             spk;
    logic             refr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  lif_neuron_core_if #(
    .WIDTH(WIDTH), .N_IN(N_IN), .W_WIDTH(W_WIDTH), .REFRAC_W(REFRAC_W)
  ) bus ();

  lif_neuron_core #(
    .WIDTH(WIDTH), .N_IN(N_IN), .W_WIDTH(W_WIDTH), .REFRAC_W(REFRAC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs
  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_membrane"},   32'(bus.membrane),   32'(e.mem));
      chk({tag, "_spike_out"},  32'(bus.spike_out),  32'(e.spk));
      chk({tag, "_refractory"}, 32'(bus.refractory), 32'(e.refr));
    end
  endtask

  // One clock: drive inputs, queue what the outputs must show after the edge, then check
  task automatic step(input logic e, input logic [N_IN-1:0] s,
                      input int m, input bit sp, input bit rf, input string tag);
    exp_t x;
    x.mem  = WIDTH'(m);
    x.spk  = sp;
    x.refr = rf;
    sb.push_back(x);
    bus.en       = e;
    bus.spike_in = s;
    @(posedge clk);
    #1;
    compare_head(tag);
  endtask

  initial begin
    exp_t x;
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.spike_in   = '0;
    bus.weights    = '0;
    bus.threshold  = '0;
    bus.leak_amt   = '0;
    bus.refrac_len = '0;

    repeat (2) @(posedge clk);
    #1;
    x = '0;
    sb.push_back(x);
    compare_head("reset");
    rst_n = 1'b1;

    // Async reset mid-integration at membrane 37
    bus.weights = 16'h07FF;
    step(1'b1, 4'b0111, 37, 1'b0, 1'b0, "t1_charge");
    bus.en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    x = '0;
    sb.push_back(x);
    compare_head("t1_async_rst");
    #2;
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 0, 1'b0, 1'b0, "t1_post_rst");
    step(1'b1, 4'b0000, 0, 1'b0, 1'b0, "t1_rest");

    // Charge to fire
    bus.weights    = 16'h0005;
    bus.threshold  = 8'd20;
    bus.leak_amt   = 8'd1;
    bus.refrac_len = '0;
    step(1'b1, 4'b0001, 4,  1'b0, 1'b0, "t2_c1");
    step(1'b1, 4'b0001, 8,  1'b0, 1'b0, "t2_c2");
    step(1'b1, 4'b0001, 12, 1'b0, 1'b0, "t2_c3");
    step(1'b1, 4'b0001, 16, 1'b0, 1'b0, "t2_c4");
    step(1'b1, 4'b0001, 0,  1'b1, 1'b0, "t2_fire");
    step(1'b0, 4'b0000, 0,  1'b0, 1'b0, "t2_after");

    // Leak floor and hold on en=0
    bus.weights   = 16'h0004;
    bus.threshold = 8'd0;
    step(1'b1, 4'b0001, 3, 1'b0, 1'b0, "t3_to3");
    bus.leak_amt = 8'd5;
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0001, 3, 1'b0, 1'b0, "t3_hold");
    step(1'b1, 4'b0000, 0, 1'b0, 1'b0, "t3_floor");
    step(1'b1, 4'b0000, 0, 1'b0, 1'b0, "t3_rest");

    // Saturation with firing disabled
    bus.weights  = 16'hFFFF;
    bus.leak_amt = 8'd0;
    step(1'b1, 4'b1111, 60,  1'b0, 1'b0, "t4_s1");
    step(1'b1, 4'b1111, 120, 1'b0, 1'b0, "t4_s2");
    step(1'b1, 4'b1111, 180, 1'b0, 1'b0, "t4_s3");
    step(1'b1, 4'b1111, 240, 1'b0, 1'b0, "t4_s4");
    step(1'b1, 4'b1111, 255, 1'b0, 1'b0, "t4_s5");
    step(1'b1, 4'b1111, 255, 1'b0, 1'b0, "t4_s6");
    bus.leak_amt = 8'd255;
    step(1'b1, 4'b0000, 0, 1'b0, 1'b0, "t4_drain");

    // Refractory period stretched by en=0
    bus.weights    = 16'h0005;
    bus.threshold  = 8'd20;
    bus.leak_amt   = 8'd1;
    bus.refrac_len = 4'd3;
    step(1'b1, 4'b0001, 4,  1'b0, 1'b0, "t5_c1");
    step(1'b1, 4'b0001, 8,  1'b0, 1'b0, "t5_c2");
    step(1'b1, 4'b0001, 12, 1'b0, 1'b0, "t5_c3");
    step(1'b1, 4'b0001, 16, 1'b0, 1'b0, "t5_c4");
    step(1'b1, 4'b0001, 0,  1'b1, 1'b0, "t5_fire");
    step(1'b0, 4'b1111, 0,  1'b0, 1'b1, "t5_ref_enter");
    step(1'b1, 4'b1111, 0,  1'b0, 1'b1, "t5_ref_en1");
    step(1'b0, 4'b1111, 0,  1'b0, 1'b1, "t5_ref_en0");
    step(1'b1, 4'b1111, 0,  1'b0, 1'b1, "t5_ref_en1b");
    step(1'b1, 4'b1111, 0,  1'b0, 1'b0, "t5_ref_exit");
    step(1'b1, 4'b0001, 4,  1'b0, 1'b0, "t5_resume");

    // Non-adaptive: the second spike needs the same five steps as the first
    bus.refrac_len = '0;
    step(1'b1, 4'b0001, 8,  1'b0, 1'b0, "t6_c2");
    step(1'b1, 4'b0001, 12, 1'b0, 1'b0, "t6_c3");
    step(1'b1, 4'b0001, 16, 1'b0, 1'b0, "t6_c4");
    step(1'b1, 4'b0001, 0,  1'b1, 1'b0, "t6_fire1");
    step(1'b0, 4'b0000, 0,  1'b0, 1'b0, "t6_rest");
    step(1'b1, 4'b0001, 4,  1'b0, 1'b0, "t6_d1");
    step(1'b1, 4'b0001, 8,  1'b0, 1'b0, "t6_d2");
    step(1'b1, 4'b0001, 12, 1'b0, 1'b0, "t6_d3");
    step(1'b1, 4'b0001, 16, 1'b0, 1'b0, "t6_d4");
    step(1'b1, 4'b0001, 0,  1'b1, 1'b0, "t6_fire2");
    step(1'b0, 4'b0000, 0,  1'b0, 1'b0, "t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
